// File: rtl/exc_cnt_wb.sv
// Register-file write-port arbiter: passes pipeline writeback through and injects
// shadowed exception counters (X29/X30) into free slots, requesting a bubble when starved.
module exc_cnt_wb #(
  parameter int unsigned N       = 64,
  parameter int unsigned AGE_MAX = 4,
  parameter int unsigned EXT_REG = 29,
  parameter int unsigned OP_REG  = 30
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ext_irq,
  input  logic         bad_op,
  input  logic         wb_we,
  input  logic [4:0]   wb_wa,
  input  logic [N-1:0] wb_wd,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic         stall_req,
  output logic [N-1:0] ext_cnt,
  output logic [N-1:0] op_cnt
);

  localparam int unsigned AW   = 5;
  localparam int unsigned AGEW = 4;
  localparam logic [AW-1:0]   EXT_A   = AW'(EXT_REG);
  localparam logic [AW-1:0]   OP_A    = AW'(OP_REG);
  localparam logic [AGEW-1:0] AGE_LIM = AGEW'(AGE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [AGEW-1:0] age_q, age_d;
  logic           rr_q, rr_d;
  logic           stall_q, stall_d;
  logic           dirty_ext_q, dirty_ext_d;
  logic           dirty_op_q, dirty_op_d;
  logic [N-1:0]   ext_cnt_q, ext_cnt_d;
  logic [N-1:0]   op_cnt_q, op_cnt_d;

  logic inj_ext, inj_op, inj_any;
  logic snoop_ext, snoop_op;
  logic any_dirty_q, any_dirty_d;

  assign snoop_ext   = wb_we && (wb_wa == EXT_A);
  assign snoop_op    = wb_we && (wb_wa == OP_A);
  assign inj_any     = inj_ext | inj_op;
  assign any_dirty_q = dirty_ext_q | dirty_op_q;
  assign any_dirty_d = dirty_ext_d | dirty_op_d;

  // Free-slot grant; round-robin only matters when both counters are dirty.
  always_comb begin
    inj_ext = 1'b0;
    inj_op  = 1'b0;
    if (!wb_we) begin
      if (dirty_ext_q && dirty_op_q) begin
        inj_ext = !rr_q;
        inj_op  = rr_q;
      end else begin
        inj_ext = dirty_ext_q;
        inj_op  = dirty_op_q;
      end
    end
  end

  // Write-port mux; the write enable is held off while reset is asserted.
  always_comb begin
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    if (reset_n) begin
      if (wb_we) begin
        we3 = 1'b1;
        wa3 = wb_wa;
        wd3 = wb_wd;
      end else if (inj_ext) begin
        we3 = 1'b1;
        wa3 = EXT_A;
        wd3 = ext_cnt_q;
      end else if (inj_op) begin
        we3 = 1'b1;
        wa3 = OP_A;
        wd3 = op_cnt_q;
      end
    end
  end

  // External-interrupt counter: a software write replaces the shadow, then any event adds on top.
  always_comb begin
    ext_cnt_d   = ext_cnt_q;
    dirty_ext_d = dirty_ext_q;
    if (snoop_ext) begin
      ext_cnt_d   = wb_wd + N'(ext_irq);
      dirty_ext_d = ext_irq;
    end else if (ext_irq) begin
      ext_cnt_d   = ext_cnt_q + N'(1'b1);
      dirty_ext_d = 1'b1;
    end else if (inj_ext) begin
      dirty_ext_d = 1'b0;
    end
  end

  always_comb begin
    op_cnt_d   = op_cnt_q;
    dirty_op_d = dirty_op_q;
    if (snoop_op) begin
      op_cnt_d   = wb_wd + N'(bad_op);
      dirty_op_d = bad_op;
    end else if (bad_op) begin
      op_cnt_d   = op_cnt_q + N'(1'b1);
      dirty_op_d = 1'b1;
    end else if (inj_op) begin
      dirty_op_d = 1'b0;
    end
  end

  assign rr_d = rr_q ^ inj_any;

  // Starvation tracking: age counts busy cycles while something is dirty.
  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    unique case (state_q)
      IDLE: begin
        age_d = '0;
        if (any_dirty_d) state_d = PEND;
      end
      PEND: begin
        if (wb_we && any_dirty_q && (age_q != '1)) age_d = age_q + AGEW'(1);
        if (!any_dirty_d) begin
          state_d = IDLE;
          age_d   = '0;
        end else if (age_d >= AGE_LIM) begin
          state_d = FORCE;
        end
      end
      FORCE: begin
        if (inj_any) age_d = '0;
        if (!any_dirty_d) begin
          state_d = IDLE;
          age_d   = '0;
        end else if (inj_any) begin
          state_d = PEND;
        end
      end
      default: begin
        state_d = IDLE;
        age_d   = '0;
      end
    endcase
  end

  assign stall_d = (state_d == FORCE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      age_q       <= '0;
      rr_q        <= 1'b0;
      stall_q     <= 1'b0;
      dirty_ext_q <= 1'b0;
      dirty_op_q  <= 1'b0;
      ext_cnt_q   <= '0;
      op_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      age_q       <= age_d;
      rr_q        <= rr_d;
      stall_q     <= stall_d;
      dirty_ext_q <= dirty_ext_d;
      dirty_op_q  <= dirty_op_d;
      ext_cnt_q   <= ext_cnt_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  assign stall_req = stall_q;
  assign ext_cnt   = ext_cnt_q;
  assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_exc_cnt_wb.sv
// Bench for exc_cnt_wb: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model of the counters and arbitration.
module tb_exc_cnt_wb;

  localparam int unsigned N       = 64;
  localparam int unsigned AGE_MAX = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ext_irq = 1'b0;
  logic          bad_op = 1'b0;
  logic          wb_we = 1'b0;
  logic [4:0]    wb_wa = '0;
  logic [N-1:0]  wb_wd = '0;
  logic          we3;
  logic [4:0]    wa3;
  logic [N-1:0]  wd3;
  logic          stall_req;
  logic [N-1:0]  ext_cnt;
  logic [N-1:0]  op_cnt;

  exc_cnt_wb #(.N(N), .AGE_MAX(AGE_MAX), .EXT_REG(29), .OP_REG(30)) dut (
    .clk(clk), .reset_n(reset_n), .ext_irq(ext_irq), .bad_op(bad_op),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3), .stall_req(stall_req),
    .ext_cnt(ext_cnt), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [63:0] m_ext, m_op;
  bit          m_dext, m_dop, m_rr, m_stall;
  int          m_wait;

  // Snapshot of DUT outputs from the latest step
  logic        s_we3, s_stall;
  logic [4:0]  s_wa3;
  logic [63:0] s_wd3, s_ext, s_op;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ext = '0; m_op = '0; m_dext = 0; m_dop = 0; m_rr = 0; m_stall = 0; m_wait = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input bit irq, input bit bad, input bit we,
                      input logic [4:0] wa, input logic [63:0] wd);
    bit          e_we, inj_e, inj_o, old_pend, pend;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    @(negedge clk);
    ext_irq = irq; bad_op = bad; wb_we = we; wb_wa = wa; wb_wd = wd;
    #1;
    inj_e = 0; inj_o = 0;
    if (we) begin
      e_we = 1; e_wa = wa; e_wd = wd;
    end else if (m_dext && (!m_dop || !m_rr)) begin
      inj_e = 1; e_we = 1; e_wa = 5'd29; e_wd = m_ext;
    end else if (m_dop) begin
      inj_o = 1; e_we = 1; e_wa = 5'd30; e_wd = m_op;
    end else begin
      e_we = 0; e_wa = '0; e_wd = '0;
    end
    check("we3", 64'(we3), 64'(e_we));
    check("wa3", 64'(wa3), 64'(e_wa));
    check("wd3", wd3, e_wd);
    check("stall_req", 64'(stall_req), 64'(m_stall));
    check("ext_cnt", ext_cnt, m_ext);
    check("op_cnt", op_cnt, m_op);
    s_we3 = we3; s_wa3 = wa3; s_wd3 = wd3; s_stall = stall_req; s_ext = ext_cnt; s_op = op_cnt;

    old_pend = m_dext | m_dop;
    if (we && wa == 5'd29) begin m_ext = wd + 64'(irq); m_dext = irq; end
    else if (irq) begin m_ext = m_ext + 1; m_dext = 1; end
    else if (inj_e) m_dext = 0;
    if (we && wa == 5'd30) begin m_op = wd + 64'(bad); m_dop = bad; end
    else if (bad) begin m_op = m_op + 1; m_dop = 1; end
    else if (inj_o) m_dop = 0;
    m_rr = m_rr ^ (inj_e | inj_o);
    pend = m_dext | m_dop;
    if (!pend) begin
      m_stall = 0; m_wait = 0;
    end else if (m_stall) begin
      if (inj_e | inj_o) begin m_stall = 0; m_wait = 0; end
    end else begin
      if (old_pend && we) m_wait++;
      if (m_wait >= int'(AGE_MAX)) m_stall = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; ext_irq = 0; bad_op = 0; wb_we = 0; wb_wa = '0; wb_wd = '0;
    #1;
    check("rst_we3", 64'(we3), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_ext", ext_cnt, 64'd0);
    check("rst_op", op_cnt, 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    bit          irq, bad, we;
    logic [4:0]  wa;
    logic [63:0] wd;
    int unsigned r;
    model_reset();
    do_reset();

    // Single interrupt into a free slot
    step(1, 0, 0, 5'd0, 64'd0);
    step(0, 0, 0, 5'd0, 64'd0);
    check("A_we3", 64'(s_we3), 64'd1);
    check("A_wa3", 64'(s_wa3), 64'd29);
    check("A_wd3", s_wd3, 64'd1);
    step(0, 0, 0, 5'd0, 64'd0);
    check("A_ext", s_ext, 64'd1);
    check("A_idle", 64'(s_we3), 64'd0);

    // Simultaneous events: X29 then X30, no stall
    do_reset();
    step(1, 1, 0, 5'd0, 64'd0);
    step(0, 0, 0, 5'd0, 64'd0);
    check("B_wa3_1", 64'(s_wa3), 64'd29);
    check("B_wd3_1", s_wd3, 64'd1);
    check("B_stall_1", 64'(s_stall), 64'd0);
    step(0, 0, 0, 5'd0, 64'd0);
    check("B_wa3_2", 64'(s_wa3), 64'd30);
    check("B_wd3_2", s_wd3, 64'd1);
    check("B_stall_2", 64'(s_stall), 64'd0);

    // Starved opcode counter forces a stall after AGE_MAX busy cycles
    do_reset();
    step(0, 1, 1, 5'd5, 64'd11);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 5'd5, 64'd12);
      check("C_nostall", 64'(s_stall), 64'd0);
    end
    step(0, 0, 1, 5'd5, 64'd13);
    check("C_stall", 64'(s_stall), 64'd1);
    step(0, 0, 0, 5'd0, 64'd0);
    check("C_inj_we", 64'(s_we3), 64'd1);
    check("C_inj_wa", 64'(s_wa3), 64'd30);
    check("C_inj_wd", s_wd3, 64'd1);
    step(0, 0, 0, 5'd0, 64'd0);
    check("C_unstall", 64'(s_stall), 64'd0);
    check("C_quiet", 64'(s_we3), 64'd0);

    // Software write to X29 coincident with an interrupt
    do_reset();
    step(1, 0, 1, 5'd29, 64'd100);
    step(0, 0, 0, 5'd0, 64'd0);
    check("D_wa3", 64'(s_wa3), 64'd29);
    check("D_wd3", s_wd3, 64'd101);
    check("D_ext", s_ext, 64'd101);

    // Software write to X30 clears a pending injection
    do_reset();
    step(0, 1, 1, 5'd3, 64'd55);
    step(0, 0, 1, 5'd30, 64'd7);
    step(0, 0, 0, 5'd0, 64'd0);
    check("E_noinj", 64'(s_we3), 64'd0);
    check("E_op", s_op, 64'd7);

    // Async reset while ext is dirty and stall is asserted
    do_reset();
    step(1, 0, 1, 5'd5, 64'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 5'd5, 64'd0);
    check("F_stall", 64'(s_stall), 64'd1);
    @(negedge clk);
    ext_irq = 0; bad_op = 0; wb_we = 0;
    #2 reset_n = 0;
    #1;
    check("F_we3", 64'(we3), 64'd0);
    check("F_stall_rst", 64'(stall_req), 64'd0);
    check("F_ext_rst", ext_cnt, 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    step(0, 0, 0, 5'd0, 64'd0);
    check("F_noinj", 64'(s_we3), 64'd0);
    step(0, 0, 0, 5'd0, 64'd0);
    check("F_noinj2", 64'(s_we3), 64'd0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      irq = ($urandom_range(0, 7) == 0);
      bad = ($urandom_range(0, 7) == 0);
      if (m_stall) we = ($urandom_range(0, 2) == 0);
      else         we = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r == 0)      wa = 5'd29;
      else if (r == 1) wa = 5'd30;
      else if (r == 2) wa = 5'd31;
      else             wa = 5'($urandom_range(0, 31));
      wd = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 15) == 0) wd = 64'hFFFF_FFFF_FFFF_FFFF;
      step(irq, bad, we, wa, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
